core_run_ctrl: RTL

Run-sequencing controller for the single-cycle core. Owns `should_run_processor` into the program counter and sequences a program run: start handshake, PC clear, execution, halt/fault termination, a post-run flush window, and a sticky done/status report to the test harness. Also counts executed cycles and supervises the PC against the program image size.

---
 rtl/core_run_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/core_run_ctrl.sv
// core_run_ctrl
// -------------
// Run-sequencing controller for the single-cycle core. It owns the run enable
// into the program counter and sequences one program run: a start handshake,
// a one-cycle PC clear (ARM), execution (RUN), termination on halt, PC fault or
// watchdog, a post-run flush window (FLUSH) and a sticky done/status report
// (DONE). It also counts executed RUN cycles.
//
// Configuration macro: CORE_RUN_CTRL_TIMEOUT_EN
//   defined   : MAX_CYCLES watchdog active, status 10 on expiry, counter wraps
//               (never reached, since MAX_CYCLES < 2^CNT_W)
//   undefined : no watchdog, RUN ends only on halt or PC fault, cycle_count
//               saturates at all-ones, MAX_CYCLES is only range-checked
//
// Parameters:
//   CNT_W        width of the cycle counter
//   MAX_CYCLES   watchdog limit in RUN cycles (1 <= MAX_CYCLES < 2^CNT_W)
//   PROG_WORDS   instruction memory depth, PC >= PROG_WORDS is a fault
//   FLUSH_CYCLES length of the post-run window with run low (>= 1)
//
// Ports:
//   clk                  clock
//   reset                asynchronous, active-high reset
//   start                run request, honoured in IDLE or DONE
//   halt_decoded         instruction at the current PC is HALT
//   pc                   current program counter (unsigned compare)
//   should_run_processor registered run enable to the PC and core
//   busy                 high in ARM, RUN and FLUSH
//   done                 high in DONE
//   status               00 none, 01 halted, 10 timeout, 11 PC out of range
//   cycle_count          RUN cycles in the current or last run

module core_run_ctrl #(
  parameter int CNT_W        = 16,
  parameter int MAX_CYCLES   = 4096,
  parameter int PROG_WORDS   = 256,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_decoded,
  input  logic [31:0]      pc,
  output logic             should_run_processor,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_HALTED  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_FAULT   = 2'b11;

  // The flush counter only has to hold FLUSH_CYCLES-1.
  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FL_W-1:0] FLUSH_LOAD = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [31:0]     PROG_LIMIT = 32'(PROG_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Reject parameter sets the sequencing cannot honour.
  if (FLUSH_CYCLES < 1) begin : g_bad_flush
    $error("core_run_ctrl: FLUSH_CYCLES must be at least 1");
  end
  if (MAX_CYCLES < 1 || (CNT_W < 32 && MAX_CYCLES >= (1 << CNT_W))) begin : g_bad_max
    $error("core_run_ctrl: MAX_CYCLES must satisfy 1 <= MAX_CYCLES < 2^CNT_W");
  end

  state_t          state_q;
  logic            run_q;
  logic            busy_q;
  logic            done_q;
  logic [1:0]      status_q;
  logic [CNT_W-1:0] count_q;
  logic [FL_W-1:0] flush_q;

  logic            pc_fault;
  logic            timeout_hit;
  logic            run_end;
  logic [1:0]      status_d;
  logic [CNT_W-1:0] count_d;

  assign pc_fault = (pc >= PROG_LIMIT);

`ifdef CORE_RUN_CTRL_TIMEOUT_EN
  // The watchdog fires on the MAX_CYCLES-th RUN cycle, i.e. when the count
  // before this cycle's increment is MAX_CYCLES-1. The counter can never
  // reach all-ones first, so a plain increment is enough.
  assign timeout_hit = (count_q == CNT_LAST);
  assign count_d     = count_q + 1'b1;
`else
  // Without a watchdog a run can last arbitrarily long, so the counter
  // saturates rather than wrapping to a misleading small value.
  assign timeout_hit = 1'b0;
  assign count_d     = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
`endif

  assign run_end = pc_fault | halt_decoded | timeout_hit;

  // Termination priority: PC fault beats halt, halt beats the watchdog.
  always_comb begin
    status_d = ST_NONE;
    if (pc_fault) begin
      status_d = ST_FAULT;
    end else if (halt_decoded) begin
      status_d = ST_HALTED;
    end else if (timeout_hit) begin
      status_d = ST_TIMEOUT;
    end
  end

  // Run sequencer. Every output is a register updated on the same edge as the
  // state transition it belongs to, so run drops on the very edge that samples
  // the terminating event, and done/busy change on the edge entering or
  // leaving DONE. Reset drops everything immediately, including mid-run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= ST_NONE;
      count_q  <= '0;
      flush_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_ARM;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            status_q <= ST_NONE;
            count_q  <= '0;
          end
        end
        S_ARM: begin
          state_q <= S_RUN;
          run_q   <= 1'b1;
        end
        S_RUN: begin
          count_q <= count_d;
          if (run_end) begin
            state_q  <= S_FLUSH;
            run_q    <= 1'b0;
            status_q <= status_d;
            flush_q  <= FLUSH_LOAD;
          end
        end
        S_FLUSH: begin
          if (flush_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            flush_q <= flush_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          run_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign should_run_processor = run_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign status               = status_q;
  assign cycle_count          = count_q;

endmodule
